// File: rtl/aes_add_round_key_if.sv
// Beat-level stream bundle for the AddRoundKey stage: the upstream ShiftRows/MixColumn
// side and the downstream output register side share one interface.
interface aes_add_round_key_if #(
    parameter int KA_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic            in_first;
    logic [127:0]    in_mix;
    logic [127:0]    in_shift;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    out_data;
    logic [KA_W-1:0] out_round;
    logic            out_last;

    modport master (
        output in_valid, in_first, in_mix, in_shift, out_ready,
        input  in_ready, out_valid, out_data, out_round, out_last
    );

    modport slave (
        input  in_valid, in_first, in_mix, in_shift, out_ready,
        output in_ready, out_valid, out_data, out_round, out_last
    );
endinterface

// File: rtl/aes_add_round_key.sv
// AES-128 AddRoundKey stage: round-key file, per-block round tracking, source select
// between the ShiftRows and MixColumn paths, and a one-deep registered output.
module aes_add_round_key #(
    parameter int NR   = 10,
    parameter int KA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_wr_en,
    input  logic [KA_W-1:0]       key_wr_addr,
    input  logic [127:0]          key_wr_data,
    aes_add_round_key_if.slave    bus,
    output logic                  err
);

    localparam logic [KA_W-1:0] LAST_ROUND = KA_W'(NR);

    logic [127:0]    key_file [0:NR];
    logic [KA_W-1:0] rc;
    logic            out_valid_q;
    logic [127:0]    out_data_q;
    logic [KA_W-1:0] out_round_q;
    logic            out_last_q;
    logic            err_q;

    logic            accept;
    logic            idle;
    logic            key_addr_ok;
    logic            key_we;
    logic            key_err;

    logic            beat_emit;
    logic            beat_err;
    logic [127:0]    beat_data;
    logic [KA_W-1:0] beat_round;
    logic            beat_last;
    logic [KA_W-1:0] rc_next;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_last_q;
    assign err           = err_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Idle is judged on pre-edge state, so a write alongside an accepted first beat
    // still lands while that beat whitens with the previous key[0].
    assign idle        = (rc == '0) && !out_valid_q;
    assign key_addr_ok = key_wr_addr <= LAST_ROUND;
    assign key_we      = key_wr_en && idle && key_addr_ok;
    assign key_err     = key_wr_en && !(idle && key_addr_ok);

    always_comb begin
        beat_emit  = 1'b0;
        beat_err   = 1'b0;
        beat_data  = '0;
        beat_round = '0;
        beat_last  = 1'b0;
        rc_next    = rc;
        if (bus.in_first) begin
            beat_emit  = 1'b1;
            beat_err   = (rc != '0);
            beat_data  = bus.in_shift ^ key_file[0];
            beat_round = '0;
            rc_next    = KA_W'(1);
        end else if (rc == '0) begin
            // Continuation beat with no block open: swallowed and flagged.
            beat_err   = 1'b1;
        end else if (rc == LAST_ROUND) begin
            beat_emit  = 1'b1;
            beat_data  = bus.in_shift ^ key_file[NR];
            beat_round = LAST_ROUND;
            beat_last  = 1'b1;
            rc_next    = '0;
        end else begin
            beat_emit  = 1'b1;
            beat_data  = bus.in_mix ^ key_file[rc];
            beat_round = rc;
            rc_next    = rc + KA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc          <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                key_file[i] <= '0;
            end
        end else begin
            err_q <= (accept && beat_err) || key_err;
            if (accept) begin
                rc          <= rc_next;
                out_valid_q <= beat_emit;
                if (beat_emit) begin
                    out_data_q  <= beat_data;
                    out_round_q <= beat_round;
                    out_last_q  <= beat_last;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (key_we) begin
                key_file[key_wr_addr] <= key_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_aes_add_round_key.sv
// Self-checking bench for aes_add_round_key: FIPS-197 vectors, directed protocol corner
// cases and a randomized phase, all checked against a cycle-level reference model.
module tb_aes_add_round_key;

    localparam int NR   = 10;
    localparam int KA_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            key_wr_en;
    logic [KA_W-1:0] key_wr_addr;
    logic [127:0]    key_wr_data;
    logic            err;

    aes_add_round_key_if #(.KA_W(KA_W)) bus ();

    aes_add_round_key #(.NR(NR), .KA_W(KA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .bus         (bus),
        .err         (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [127:0] m_key [0:NR];
    int           m_rc;
    bit           m_ov;
    logic [127:0] m_data;
    int           m_round;
    bit           m_last;
    bit           m_err;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic applyStimulus(input bit r, input bit kwe, input logic [KA_W-1:0] kaddr,
                                 input logic [127:0] kdata, input bit iv, input bit first,
                                 input logic [127:0] mix, input logic [127:0] shift, input bit ordy);
        bit idle;
        bit acc;
        bit kbad;
        bit perr;
        @(negedge clk);
        rst          = r;
        key_wr_en    = kwe;
        key_wr_addr  = kaddr;
        key_wr_data  = kdata;
        bus.in_valid = iv;
        bus.in_first = first;
        bus.in_mix   = mix;
        bus.in_shift = shift;
        bus.out_ready = ordy;
        #1;
        checkOutput("in_ready", 128'(bus.in_ready), 128'(!m_ov || ordy));

        if (r) begin
            for (int i = 0; i <= NR; i++) m_key[i] = '0;
            m_rc = 0; m_ov = 0; m_data = '0; m_round = 0; m_last = 0; m_err = 0;
        end else begin
            idle = (m_rc == 0) && !m_ov;
            acc  = iv && (!m_ov || ordy);
            kbad = kwe && (!idle || int'(kaddr) > NR);
            perr = 0;
            if (acc) begin
                if (first) begin
                    perr = (m_rc != 0);
                    m_data = shift ^ m_key[0]; m_round = 0; m_last = 0; m_ov = 1; m_rc = 1;
                end else if (m_rc == 0) begin
                    perr = 1; m_ov = 0;
                end else if (m_rc == NR) begin
                    m_data = shift ^ m_key[NR]; m_round = NR; m_last = 1; m_ov = 1; m_rc = 0;
                end else begin
                    m_data = mix ^ m_key[m_rc]; m_round = m_rc; m_last = 0; m_ov = 1; m_rc = m_rc + 1;
                end
            end else if (ordy) begin
                m_ov = 0;
            end
            if (kwe && !kbad) m_key[kaddr] = kdata;
            m_err = kbad || perr;
        end

        @(posedge clk);
        #1;
        checkOutput("out_valid", 128'(bus.out_valid), 128'(m_ov));
        checkOutput("err", 128'(err), 128'(m_err));
        if (m_ov || r) begin
            checkOutput("out_data", bus.out_data, m_data);
            checkOutput("out_round", 128'(bus.out_round), 128'(m_round));
            checkOutput("out_last", 128'(bus.out_last), 128'(m_last));
        end
    endtask

    task automatic beat(input bit first, input logic [127:0] mix, input logic [127:0] shift, input bit ordy);
        applyStimulus(0, 0, '0, '0, 1, first, mix, shift, ordy);
    endtask

    task automatic idleCycle(input bit ordy);
        applyStimulus(0, 0, '0, '0, 0, 0, rnd128(), rnd128(), ordy);
    endtask

    task automatic keyWrite(input logic [KA_W-1:0] addr, input logic [127:0] data);
        applyStimulus(0, 1, addr, data, 0, 0, '0, '0, 1);
    endtask

    task automatic resetCycle();
        applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 1);
    endtask

    // Runs rounds start..NR of the current block with random data, downstream always ready.
    task automatic finishBlock();
        while (m_rc != 0) beat(0, rnd128(), rnd128(), 1);
    endtask

    logic [127:0] held;

    initial begin
        rst = 1; key_wr_en = 0; key_wr_addr = '0; key_wr_data = '0;
        bus.in_valid = 0; bus.in_first = 0; bus.in_mix = '0; bus.in_shift = '0; bus.out_ready = 1;
        for (int i = 0; i <= NR; i++) m_key[i] = '0;
        m_rc = 0; m_ov = 0; m_data = '0; m_round = 0; m_last = 0; m_err = 0;

        resetCycle();
        resetCycle();

        // FIPS-197 round 0 and final round
        keyWrite(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int i = 1; i < NR; i++) keyWrite(KA_W'(i), rnd128());
        keyWrite(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        beat(1, rnd128(), 128'h3243f6a8885a308d313198a2e0370734, 1);
        checkOutput("fips_round0", bus.out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        for (int i = 1; i < NR; i++) beat(0, rnd128(), rnd128(), 1);
        beat(0, rnd128(), 128'he9317db5cb322c723d2e895faf090794, 1);
        checkOutput("fips_final", bus.out_data, 128'h3925841d02dc09fbdc118597196a0b32);
        checkOutput("fips_last", 128'(bus.out_last), 128'(1));
        idleCycle(1);

        // Backpressure: stall 5 cycles, then stream the rest back to back
        beat(1, rnd128(), rnd128(), 0);
        held = bus.out_data;
        for (int i = 0; i < 5; i++) beat(0, rnd128(), rnd128(), 0);
        checkOutput("stall_hold", bus.out_data, held);
        finishBlock();
        idleCycle(1);

        // Abort with in_first at rc=4, then a complete block
        beat(1, rnd128(), rnd128(), 1);
        for (int i = 0; i < 3; i++) beat(0, rnd128(), rnd128(), 1);
        beat(1, rnd128(), rnd128(), 1);
        finishBlock();
        idleCycle(1);

        // Continuation beat while idle, out-of-range key address
        beat(0, rnd128(), rnd128(), 1);
        idleCycle(1);
        keyWrite(4'd12, rnd128());
        idleCycle(1);

        // Key write mid-block is ignored; next block still uses the old key
        beat(1, rnd128(), rnd128(), 1);
        beat(0, rnd128(), rnd128(), 1);
        beat(0, rnd128(), rnd128(), 1);
        keyWrite(4'd5, rnd128());
        finishBlock();
        idleCycle(1);
        beat(1, rnd128(), rnd128(), 1);
        finishBlock();
        idleCycle(1);

        // Key write coinciding with a first beat while idle
        applyStimulus(0, 1, 4'd0, rnd128(), 1, 1, rnd128(), rnd128(), 1);
        finishBlock();
        idleCycle(1);
        beat(1, rnd128(), rnd128(), 1);
        finishBlock();
        idleCycle(1);

        // Reset mid-block with an output pending
        beat(1, rnd128(), rnd128(), 1);
        for (int i = 0; i < 5; i++) beat(0, rnd128(), rnd128(), 1);
        beat(0, rnd128(), rnd128(), 0);
        resetCycle();
        for (int i = 0; i <= NR; i++) keyWrite(KA_W'(i), rnd128());
        beat(1, rnd128(), rnd128(), 1);
        finishBlock();
        idleCycle(1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit iv;
            bit first;
            bit ordy;
            bit kwe;
            iv    = ($urandom_range(0, 3) != 0);
            ordy  = ($urandom_range(0, 2) != 0);
            kwe   = ($urandom_range(0, 24) == 0);
            first = (m_rc == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            applyStimulus(0, kwe, KA_W'($urandom_range(0, 15)), rnd128(), iv, first,
                          rnd128(), rnd128(), ordy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
